// File: rtl/hammer_seq.sv
// Exhaustive A_WIDTH-bit sweep driver plus gold-vs-gate output comparator.
// Latency: vector k is driven k+1 cycles after start; its compare lands DUT_LAT cycles later.
// Backpressure: none; start is ignored while busy, and results hold in DONE until the next start.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begins a sweep when sampled in IDLE or DONE
//   a                 stimulus driven to both test-module instances
//   y_gold, y_gate    reference and netlist outputs, compared DUT_LAT cycles after a
//   busy, done, pass  status: sweeping, finished, finished with no mismatches
//   err_count         saturating mismatch count
//   first_a           stimulus of the first mismatch
//   first_diff        y_gold ^ y_gate at the first mismatch
module hammer_seq #(
  parameter int A_WIDTH = 4,
  parameter int Y_WIDTH = 16,
  parameter int DUT_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [A_WIDTH-1:0] a,
  input  logic [Y_WIDTH-1:0] y_gold,
  input  logic [Y_WIDTH-1:0] y_gate,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [A_WIDTH-1:0] first_a,
  output logic [Y_WIDTH-1:0] first_diff
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Last value of the drain counter before DONE (only meaningful when DUT_LAT > 0).
  localparam logic [2:0] DRAIN_LAST = 3'(DUT_LAT - 1);

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [2:0]           drain_q, drain_d;
  logic [15:0]          err_q, err_d;
  logic [A_WIDTH-1:0]   fa_q, fa_d;
  logic [Y_WIDTH-1:0]   fd_q, fd_d;
  logic                 seen_q, seen_d;

  // Compare tag: which swept vector the current y inputs belong to.
  logic                 run;
  logic                 tag_vld;
  logic [A_WIDTH-1:0]   tag_a;
  logic                 mism;

  assign run = (state_q == RUN);

  generate
    if (DUT_LAT == 0) begin : g_comb
      // Combinational test module: y belongs to the vector driven this cycle.
      assign tag_vld = run;
      assign tag_a   = a_q;
    end else begin : g_pipe
      logic [DUT_LAT-1:0] vld_q;
      logic [A_WIDTH-1:0] a_pipe_q [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < DUT_LAT; i++) begin
            a_pipe_q[i] <= '0;
          end
        end else begin
          vld_q[0]    <= run;
          a_pipe_q[0] <= a_q;
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_q[i]    <= vld_q[i-1];
            a_pipe_q[i] <= a_pipe_q[i-1];
          end
        end
      end

      assign tag_vld = vld_q[DUT_LAT-1];
      assign tag_a   = a_pipe_q[DUT_LAT-1];
    end
  endgenerate

  assign mism = tag_vld && (y_gold != y_gate);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    drain_d = drain_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    seen_d  = seen_q;

    if (mism) begin
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
      // Only the first mismatch of a sweep is recorded.
      if (!seen_q) begin
        seen_d = 1'b1;
        fa_d   = tag_a;
        fd_d   = y_gold ^ y_gate;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        // No compare can be pending here, so clearing wins unconditionally.
        if (start) begin
          state_d = RUN;
          a_d     = '0;
          err_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
          seen_d  = 1'b0;
        end
      end
      RUN: begin
        if (a_q == {A_WIDTH{1'b1}}) begin
          // Hold all-ones; the last vector stays on the bus while draining.
          state_d = (DUT_LAT > 0) ? DRAIN : DONE;
          drain_d = '0;
        end else begin
          a_d = a_q + A_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      drain_q <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
      seen_q  <= seen_d;
    end
  end

  assign a          = a_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == 16'd0);
  assign err_count  = err_q;
  assign first_a    = fa_q;
  assign first_diff = fd_q;

endmodule

// File: tb/tb_hammer_seq.sv
// Bench for hammer_seq: four instances cover combinational, latency-1/2 and 16-bit sweeps.
module tb_hammer_seq;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2, start16;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // u0: A=4, Y=8, combinational identical outputs.
  logic [3:0]  a0, fa0;
  logic [7:0]  yg0, fd0;
  logic [15:0] err0;
  logic        busy0, done0, pass0;
  assign yg0 = {a0, a0};

  hammer_seq #(.A_WIDTH(4), .Y_WIDTH(8), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .y_gold(yg0), .y_gate(yg0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_a(fa0), .first_diff(fd0));

  // u2: latency 2, gate corrupted (bit 0) for a=5 and a=9.
  logic [3:0]  a2, fa2;
  logic [7:0]  g2a, g2b, t2a, t2b, fd2;
  logic [15:0] err2;
  logic        busy2, done2, pass2;
  always_ff @(posedge clk) begin
    g2a <= {a2, a2};
    g2b <= g2a;
    t2a <= {a2, a2} ^ (((a2 == 4'd5) || (a2 == 4'd9)) ? 8'h01 : 8'h00);
    t2b <= t2a;
  end

  hammer_seq #(.A_WIDTH(4), .Y_WIDTH(8), .DUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .y_gold(g2b), .y_gate(t2b),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_a(fa2), .first_diff(fd2));

  // u1: latency 1, gate differs on every vector (+0x3C).
  logic [3:0]  a1, fa1;
  logic [7:0]  g1, t1, fd1;
  logic [15:0] err1;
  logic        busy1, done1, pass1;
  always_ff @(posedge clk) begin
    g1 <= {a1, a1};
    t1 <= {a1, a1} + 8'h3C;
  end

  hammer_seq #(.A_WIDTH(4), .Y_WIDTH(8), .DUT_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .y_gold(g1), .y_gate(t1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_a(fa1), .first_diff(fd1));

  // u16: A=16, every vector mismatches -> 65536 errors, must saturate.
  logic [15:0] a16, fa16, fd16, yt16, err16;
  logic        busy16, done16, pass16;
  assign yt16 = ~a16;

  hammer_seq #(.A_WIDTH(16), .Y_WIDTH(16), .DUT_LAT(0)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .y_gold(a16), .y_gate(yt16),
    .busy(busy16), .done(done16), .pass(pass16), .err_count(err16),
    .first_a(fa16), .first_diff(fd16));

  typedef struct {
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  a;
    logic [15:0] err;
  } vec_t;

  vec_t tbl [37];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulses start on instance sel, then counts cycles (cycle 1 = first after the start edge)
  // until done is seen or the bound expires (done_cyc stays 0).
  task automatic sweep(input int sel, input int bound,
                       output int done_cyc, output int busy_cyc, output logic overlap);
    logic b, d;
    done_cyc = 0;
    busy_cyc = 0;
    overlap  = 1'b0;
    case (sel)
      1:       start1  = 1'b1;
      2:       start2  = 1'b1;
      default: start16 = 1'b1;
    endcase
    step();
    start1 = 1'b0; start2 = 1'b0; start16 = 1'b0;
    for (int idx = 1; idx <= bound; idx++) begin
      case (sel)
        1:       begin b = busy1;  d = done1;  end
        2:       begin b = busy2;  d = done2;  end
        default: begin b = busy16; d = done16; end
      endcase
      if (b && d) overlap = 1'b1;
      if (b) busy_cyc++;
      if (d) begin
        done_cyc = idx;
        break;
      end
      step();
    end
  endtask

  initial begin
    int   dc, bc;
    logic ov;

    // Vector table for u0: start for the edge, expected outputs after it.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    for (int i = 1; i <= 15; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 16'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 16'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 16'd0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    // start held high through RUN must not restart the sweep
    for (int i = 19; i <= 33; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'(i - 18), 16'd0};
    tbl[34] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 16'd0};
    tbl[35] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    tbl[36] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'd0};

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start16 = 1'b0;
    repeat (3) step();

    chk("reset_u0_status", {busy0, done0, pass0, a0, err0}, 64'd0);
    chk("reset_u0_first", {fa0, fd0}, 64'd0);
    chk("reset_u2_status", {busy2, done2, pass2, a2, err2, fa2, fd2}, 64'd0);
    chk("reset_u16_status", {busy16, done16, pass16, a16, err16}, 64'd0);
    rst = 1'b0;
    step();
    chk("idle_no_start_u1", {busy1, done1, a1}, 64'd0);

    for (int i = 0; i < 37; i++) begin
      start0 = tbl[i].start;
      step();
      chk($sformatf("u0_vec%0d", i), {busy0, done0, pass0, a0, err0},
          {tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].a, tbl[i].err});
    end
    start0 = 1'b0;
    chk("u0_first_none", {fa0, fd0}, 64'd0);

    // Latency 2 with two corrupted vectors.
    sweep(2, 40, dc, bc, ov);
    chk("u2_done_cycle", dc, 19);
    chk("u2_busy_cycles", bc, 18);
    chk("u2_busy_done_excl", ov, 0);
    chk("u2_err_count", err2, 2);
    chk("u2_first_a", fa2, 5);
    chk("u2_first_diff", fd2, 8'h01);
    chk("u2_pass", pass2, 0);
    step();
    chk("u2_done_held", {done2, err2}, {1'b1, 16'd2});

    // Latency 1, all vectors mismatch.
    sweep(1, 40, dc, bc, ov);
    chk("u1_done_cycle", dc, 18);
    chk("u1_busy_cycles", bc, 17);
    chk("u1_busy_done_excl", ov, 0);
    chk("u1_err_count", err1, 16);
    chk("u1_first_a", fa1, 0);
    chk("u1_first_diff", fd1, 8'h3C);
    chk("u1_pass", pass1, 0);

    // Restart from DONE clears results, then reset mid-run discards pending compares.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("u1_restart_clear", {busy1, a1, err1, fa1, fd1}, {1'b1, 4'd0, 16'd0, 4'd0, 8'd0});
    repeat (6) step();
    chk("u1_run7_state", {busy1, a1, err1}, {1'b1, 4'd6, 16'd5});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("u1_after_rst", {busy1, done1, pass1, a1, err1, fa1, fd1}, 64'd0);
    repeat (3) step();
    chk("u1_rst_no_late_cmp", {busy1, done1, err1}, 64'd0);

    // 65536 mismatches must stop at 16'hFFFF.
    sweep(16, 66000, dc, bc, ov);
    chk("u16_done_cycle", dc, 65537);
    chk("u16_busy_done_excl", ov, 0);
    chk("u16_err_saturated", err16, 16'hFFFF);
    chk("u16_first_a", fa16, 0);
    chk("u16_first_diff", fd16, 16'hFFFF);
    chk("u16_pass", pass16, 0);
    chk("u16_a_hold", a16, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
